// File: rtl/hex_message_scroller.sv
// Scrolls one of eight fixed game messages right-to-left across the four
// rightmost seven-segment digits, emitting decoder character codes (36 = blank).
module hex_message_scroller #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] msg_sel,
    input  logic       repeat_en,
    input  logic       stop,
    output logic [6:0] hex3_code,
    output logic [6:0] hex2_code,
    output logic [6:0] hex1_code,
    output logic [6:0] hex0_code,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [6:0] BLANK = 7'd36;
    localparam logic [27:0] ALL_BLANK = {BLANK, BLANK, BLANK, BLANK};

    typedef enum logic [0:0] {ST_IDLE, ST_SCROLL} state_t;

    state_t        state_r;
    logic [2:0]    sel_r;
    logic [3:0]    pos_r;
    logic [CW-1:0] cnt_r;
    logic [3:0]    len_s;
    logic [3:0]    start_len_s;
    logic [27:0]   win_start_s;
    logic [27:0]   win_next_s;
    logic [27:0]   win_zero_s;

    function automatic logic [3:0] msg_len_f(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'd6;
            3'd1:    return 4'd6;
            3'd2:    return 4'd4;
            3'd3:    return 4'd3;
            3'd4:    return 4'd4;
            3'd5:    return 4'd4;
            3'd6:    return 4'd2;
            default: return 4'd0;
        endcase
    endfunction

    // Key is {message, character index} in octal: one digit each.
    function automatic logic [6:0] msg_code_f(input logic [2:0] sel, input logic [2:0] idx);
        case ({sel, idx})
            6'o00: return 7'd25;  6'o01: return 7'd21;  6'o02: return 7'd10;
            6'o03: return 7'd34;  6'o04: return 7'd14;  6'o05: return 7'd27;
            6'o10: return 7'd13;  6'o11: return 7'd14;  6'o12: return 7'd10;
            6'o13: return 7'd21;  6'o14: return 7'd14;  6'o15: return 7'd27;
            6'o20: return 7'd11;  6'o21: return 7'd30;  6'o22: return 7'd28;
            6'o23: return 7'd29;
            6'o30: return 7'd32;  6'o31: return 7'd18;  6'o32: return 7'd23;
            6'o40: return 7'd21;  6'o41: return 7'd24;  6'o42: return 7'd28;
            6'o43: return 7'd14;
            6'o50: return 7'd25;  6'o51: return 7'd30;  6'o52: return 7'd28;
            6'o53: return 7'd17;
            6'o60: return 7'd2;   6'o61: return 7'd1;
            default: return BLANK;
        endcase
    endfunction

    // Digit i shows character pos-3+i; anything left of or past the message is blank.
    function automatic logic [6:0] char_at_f(input logic [2:0] sel, input logic [3:0] pos,
                                             input logic [1:0] i);
        logic [4:0] k;
        logic [4:0] j;
        k = {1'b0, pos} + {3'b000, i};
        j = k - 5'd3;
        if (k < 5'd3) begin
            return BLANK;
        end else if (j >= {1'b0, msg_len_f(sel)}) begin
            return BLANK;
        end else begin
            return msg_code_f(sel, j[2:0]);
        end
    endfunction

    function automatic logic [27:0] window_f(input logic [2:0] sel, input logic [3:0] pos);
        return {char_at_f(sel, pos, 2'd0), char_at_f(sel, pos, 2'd1),
                char_at_f(sel, pos, 2'd2), char_at_f(sel, pos, 2'd3)};
    endfunction

    assign len_s       = msg_len_f(sel_r);
    assign start_len_s = msg_len_f(msg_sel);
    assign win_start_s = window_f(msg_sel, 4'd0);
    assign win_next_s  = window_f(sel_r, pos_r + 4'd1);
    assign win_zero_s  = window_f(sel_r, 4'd0);

    // Scroll state machine; every output is registered from the next window.
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            state_r <= ST_IDLE;
            sel_r   <= reset ? 3'd0 : sel_r;
            pos_r   <= 4'd0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            {hex3_code, hex2_code, hex1_code, hex0_code} <= ALL_BLANK;
        end else if (start) begin
            pos_r <= 4'd0;
            cnt_r <= '0;
            if (start_len_s == 4'd0) begin
                state_r <= ST_IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                {hex3_code, hex2_code, hex1_code, hex0_code} <= ALL_BLANK;
            end else begin
                state_r <= ST_SCROLL;
                sel_r   <= msg_sel;
                busy    <= 1'b1;
                done    <= 1'b0;
                {hex3_code, hex2_code, hex1_code, hex0_code} <= win_start_s;
            end
        end else begin
            case (state_r)
                ST_SCROLL: begin
                    done <= 1'b0;
                    if (cnt_r == CNT_MAX) begin
                        cnt_r <= '0;
                        if (pos_r < len_s + 4'd2) begin
                            pos_r <= pos_r + 4'd1;
                            {hex3_code, hex2_code, hex1_code, hex0_code} <= win_next_s;
                        end else if (repeat_en) begin
                            pos_r <= 4'd0;
                            {hex3_code, hex2_code, hex1_code, hex0_code} <= win_zero_s;
                        end else begin
                            state_r <= ST_IDLE;
                            pos_r   <= 4'd0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            {hex3_code, hex2_code, hex1_code, hex0_code} <= ALL_BLANK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_message_scroller.sv
// Directed bench for hex_message_scroller with TICK_DIV=4; inputs change and
// outputs are sampled on the falling edge.
module tb_hex_message_scroller;

    logic       clk = 1'b0;
    logic       reset, start, repeat_en, stop;
    logic [2:0] msg_sel;
    logic [6:0] hex3_code, hex2_code, hex1_code, hex0_code;
    logic       busy, done;
    int         n_tests = 0;
    int         n_fail = 0;

    hex_message_scroller #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .msg_sel(msg_sel),
        .repeat_en(repeat_en), .stop(stop),
        .hex3_code(hex3_code), .hex2_code(hex2_code),
        .hex1_code(hex1_code), .hex0_code(hex0_code),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [27:0] w(input int a, input int b, input int c, input int d);
        return {7'(a), 7'(b), 7'(c), 7'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_win"}, {4'h0, hex3_code, hex2_code, hex1_code, hex0_code},
              {4'h0, w(36, 36, 36, 36)});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
    endtask

    task automatic check_scroll(input string tag, input logic [27:0] exp_win);
        check({tag, "_win"}, {4'h0, hex3_code, hex2_code, hex1_code, hex0_code},
              {4'h0, exp_win});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // Pulses start for one cycle; returns on the falling edge after the sampling edge.
    task automatic pulse_start(input logic [2:0] sel);
        start = 1'b1;
        msg_sel = sel;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [27:0] bust_w[7];
    logic [27:0] tw1_w[5];

    initial begin
        bust_w = '{w(36,36,36,11), w(36,36,11,30), w(36,11,30,28), w(11,30,28,29),
                   w(30,28,29,36), w(28,29,36,36), w(29,36,36,36)};
        tw1_w  = '{w(36,36,36,2), w(36,36,2,1), w(36,2,1,36), w(2,1,36,36), w(1,36,36,36)};

        reset = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0; msg_sel = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset", 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // "bUSt" single pass: seven windows of four cycles, then done.
        pulse_start(3'd2);
        for (int k = 0; k < 28; k++) begin
            check_scroll("bust", bust_w[k / 4]);
            @(negedge clk);
        end
        check_idle("bust_end", 1'b1);
        @(negedge clk);
        check_idle("bust_after", 1'b0);

        // "21" looping, then stop looping on the second pass.
        repeat_en = 1'b1;
        pulse_start(3'd6);
        for (int k = 0; k < 20; k++) begin
            check_scroll("loop1", tw1_w[k / 4]);
            @(negedge clk);
        end
        check_scroll("loop_wrap", tw1_w[0]);
        repeat_en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            check_scroll("loop2", tw1_w[k / 4]);
            @(negedge clk);
        end
        check_idle("loop_end", 1'b1);
        @(negedge clk);

        // Empty message: no scroll, done one cycle later.
        pulse_start(3'd7);
        check_idle("empty", 1'b1);
        @(negedge clk);
        check_idle("empty_after", 1'b0);
        @(negedge clk);

        // Restart mid-scroll with "WIn" at p=2 of "PLAYEr".
        pulse_start(3'd0);
        repeat (8) @(negedge clk);
        check_scroll("player_p2", w(36,25,21,10));
        @(negedge clk);
        pulse_start(3'd3);
        for (int k = 0; k < 4; k++) begin
            check_scroll("restart_p0", w(36,36,36,32));
            @(negedge clk);
        end
        check_scroll("restart_p1", w(36,36,32,18));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check_idle("stop_win", 1'b0);
        @(negedge clk);

        // start and stop together while idle: stop wins.
        stop = 1'b1;
        pulse_start(3'd2);
        stop = 1'b0;
        check_idle("startstop", 1'b0);
        @(negedge clk);
        check_idle("startstop2", 1'b0);

        // Stop mid-scroll of "LOSE": blank next cycle, never a done.
        pulse_start(3'd4);
        repeat (5) @(negedge clk);
        check_scroll("lose_p1", w(36,36,21,24));
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_idle("stop_quiet", 1'b0);
            @(negedge clk);
        end

        // Reset mid-scroll of "PUSH" at p=3, then scroll again from p=0.
        pulse_start(3'd5);
        repeat (12) @(negedge clk);
        check_scroll("push_p3", w(25,30,28,17));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("reset_mid", 1'b0);
        @(negedge clk);
        check_idle("reset_mid2", 1'b0);
        pulse_start(3'd5);
        for (int k = 0; k < 4; k++) begin
            check_scroll("push_p0", w(36,36,36,25));
            @(negedge clk);
        end
        check_scroll("push_p1", w(36,36,25,30));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
